// File: rtl/stopwatch_pkg.sv
// Shared encodings and field limits for the stopwatch timekeeping core.
// FIELD_W matches the input width of the downstream BCD encoder.
package stopwatch_pkg;
    localparam int FIELD_W = 8;

    localparam logic [FIELD_W-1:0] CENTI_MAX = 8'd99;
    localparam logic [FIELD_W-1:0] SEC_MAX   = 8'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] min;
        logic [FIELD_W-1:0] sec;
        logic [FIELD_W-1:0] cen;
    } sw_time_t;
endpackage

// File: rtl/stopwatch_button_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A level rising before edge N gives a Pulse that the consumer sees at edge N+3.
module button_sync_edge (
    input  logic Clock,
    input  logic Reset_n,
    input  logic In,
    output logic Pulse
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = In;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign Pulse = pulse_q;
endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: 100 Hz prescaler, min:sec:centi counters,
// run/pause/lap control and a registered display mux for the BCD encoders.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int MAX_MIN = 99
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               StartStop,
    input  logic               Lap,
    input  logic               Clear,
    output logic [FIELD_W-1:0] Centis,
    output logic [FIELD_W-1:0] Seconds,
    output logic [FIELD_W-1:0] Minutes,
    output logic               Running,
    output logic               LapActive,
    output logic               Wrap
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(DIV - 1);
    localparam logic [FIELD_W-1:0] MIN_MAX    = FIELD_W'(MAX_MIN);

    logic ss_p, lap_p, clr_p;

    button_sync_edge u_ss  (.Clock(Clock), .Reset_n(Reset_n), .In(StartStop), .Pulse(ss_p));
    button_sync_edge u_lap (.Clock(Clock), .Reset_n(Reset_n), .In(Lap),       .Pulse(lap_p));
    button_sync_edge u_clr (.Clock(Clock), .Reset_n(Reset_n), .In(Clear),     .Pulse(clr_p));

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    sw_time_t      live_q, live_d;
    sw_time_t      snap_q, snap_d;
    sw_time_t      disp_q, disp_d;
    logic          lap_active_q, lap_active_d;
    logic          wrap_q, wrap_d;
    logic          wrap_out_q, wrap_out_d;

    logic     tick;
    sw_time_t live_inc;

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // Post-tick value of the live count; a lap snapshot on a tick cycle takes this.
    always_comb begin
        live_inc = live_q;
        wrap_d   = 1'b0;
        if (tick) begin
            if (live_q.cen != CENTI_MAX) begin
                live_inc.cen = live_q.cen + 8'd1;
            end else begin
                live_inc.cen = '0;
                if (live_q.sec != SEC_MAX) begin
                    live_inc.sec = live_q.sec + 8'd1;
                end else begin
                    live_inc.sec = '0;
                    if (live_q.min != MIN_MAX) begin
                        live_inc.min = live_q.min + 8'd1;
                    end else begin
                        live_inc.min = '0;
                        wrap_d       = 1'b1;
                    end
                end
            end
        end
    end

    // Only the highest-priority pulse (ss > clr > lap) acts; the rest are dropped.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        live_d       = live_q;
        snap_d       = snap_q;
        lap_active_d = lap_active_q;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (ss_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                live_d  = live_inc;
                if (ss_p) begin
                    state_d = ST_PAUSE;
                end else if (clr_p) begin
                    state_d = ST_RUN;
                end else if (lap_p) begin
                    if (!lap_active_q) begin
                        snap_d       = live_inc;
                        lap_active_d = 1'b1;
                    end else begin
                        lap_active_d = 1'b0;
                    end
                end
            end
            ST_PAUSE: begin
                if (ss_p) begin
                    state_d = ST_RUN;
                end else if (clr_p) begin
                    state_d      = ST_IDLE;
                    presc_d      = '0;
                    live_d       = '0;
                    lap_active_d = 1'b0;
                end else if (lap_p) begin
                    lap_active_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        disp_d     = lap_active_q ? snap_q : live_q;
        wrap_out_d = wrap_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            live_q       <= '0;
            snap_q       <= '0;
            disp_q       <= '0;
            lap_active_q <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            live_q       <= live_d;
            snap_q       <= snap_d;
            disp_q       <= disp_d;
            lap_active_q <= lap_active_d;
            wrap_q       <= wrap_d;
            wrap_out_q   <= wrap_out_d;
        end
    end

    assign Centis    = disp_q.cen;
    assign Seconds   = disp_q.sec;
    assign Minutes   = disp_q.min;
    assign Running   = (state_q == ST_RUN);
    assign LapActive = lap_active_q;
    assign Wrap      = wrap_out_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench: the script queues time-stamped expected outputs,
// a negedge monitor pops and compares them as the cycle counter reaches each stamp.
module tb_stopwatch_counter;
    localparam bit [3:0] M_T = 4'b0001, M_R = 4'b0010, M_L = 4'b0100, M_W = 4'b1000;
    localparam bit [3:0] M_ALL = 4'b1111;

    typedef struct {
        int       cyc;
        bit       wdut;
        bit [3:0] m;
        int       t;
        bit       run;
        bit       lap;
        bit       wr;
        string    nm;
    } chk_t;

    logic       clk, rst_n;
    logic [2:0] btn;
    logic       wss;
    logic [7:0] cen, sec, mnt, w_cen, w_sec, w_mnt;
    logic       run, lap, wrap, w_run, w_lap, w_wrap;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   wrap_hi = 0;
    chk_t sbq[$];
    chk_t mc;

    stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(99)) dut (
        .Clock(clk), .Reset_n(rst_n), .StartStop(btn[0]), .Lap(btn[1]), .Clear(btn[2]),
        .Centis(cen), .Seconds(sec), .Minutes(mnt),
        .Running(run), .LapActive(lap), .Wrap(wrap));

    // Faster prescale so the full MAX_MIN=1 wrap fits in a short run.
    stopwatch_counter #(.CLK_HZ(200), .TICK_HZ(100), .MAX_MIN(1)) wdut (
        .Clock(clk), .Reset_n(rst_n), .StartStop(wss), .Lap(1'b0), .Clear(1'b0),
        .Centis(w_cen), .Seconds(w_sec), .Minutes(w_mnt),
        .Running(w_run), .LapActive(w_lap), .Wrap(w_wrap));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input bit w, input bit [3:0] m, input int t,
                             input bit r, input bit l, input bit wr, input string nm);
        chk_t e;
        int   i;
        e.cyc = c; e.wdut = w; e.m = m; e.t = t; e.run = r; e.lap = l; e.wr = wr; e.nm = nm;
        i = 0;
        while (i < sbq.size() && sbq[i].cyc <= c) i++;
        sbq.insert(i, e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m, input int c);
        wait_until(c);
        btn = m;
        wait_until(c + 2);
        btn = 3'b000;
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            logic [7:0] ac, as, am;
            logic       ar, al, aw;
            int         ec, es, em;
            bit         ok;
            mc = sbq.pop_front();
            if (mc.wdut) begin
                ac = w_cen; as = w_sec; am = w_mnt; ar = w_run; al = w_lap; aw = w_wrap;
            end else begin
                ac = cen; as = sec; am = mnt; ar = run; al = lap; aw = wrap;
            end
            ec = mc.t % 100;
            es = (mc.t / 100) % 60;
            em = mc.t / 6000;
            ok = 1'b1;
            if (mc.m[0] && (int'(ac) != ec || int'(as) != es || int'(am) != em)) ok = 1'b0;
            if (mc.m[1] && ar != mc.run) ok = 1'b0;
            if (mc.m[2] && al != mc.lap) ok = 1'b0;
            if (mc.m[3] && aw != mc.wr) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s @cyc %0d: got %0d:%0d:%0d run=%0d lap=%0d wrap=%0d, want %0d:%0d:%0d run=%0d lap=%0d wrap=%0d (mask %b)",
                         mc.nm, cyc, am, as, ac, ar, al, aw, em, es, ec, mc.run, mc.lap, mc.wr, mc.m);
            end
        end
        if (w_wrap === 1'b1) wrap_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int R, e, r, R2, l, l2, p, R3, W, RW;
        rst_n = 1'b0;
        btn   = 3'b000;
        wss   = 1'b0;
        @(negedge clk);

        // Reset and idle: everything stays zero with no button activity.
        expect_at(2, 0, M_ALL, 0, 0, 0, 0, "in_reset");
        expect_at(2, 1, M_ALL, 0, 0, 0, 0, "w_in_reset");
        for (int k = 10; k <= 50; k += 20) expect_at(k, 0, M_ALL, 0, 0, 0, 0, "idle_zero");
        wait_until(3);
        rst_n = 1'b1;

        // Start: press at 60, RUN from edge 64, tick every 10 cycles.
        R = 64;
        expect_at(R - 1, 0, M_ALL, 0, 0, 0, 0, "pre_run");
        expect_at(R, 0, M_ALL, 0, 1, 0, 0, "run_rise");
        expect_at(R + 15, 0, M_ALL, 1, 1, 0, 0, "first_tick");
        expect_at(R + 1000, 0, M_ALL, 99, 1, 0, 0, "centi_99");
        expect_at(R + 1001, 0, M_ALL, 100, 1, 0, 0, "sec_carry");
        press(3'b001, 60);

        // Pause lands on an edge where the prescaler reads 4.
        e = R + 1055;
        expect_at(e - 1, 0, M_ALL, 105, 1, 0, 0, "pre_pause");
        expect_at(e, 0, M_ALL, 105, 0, 0, 0, "pause");
        expect_at(e + 50, 0, M_ALL, 105, 0, 0, 0, "paused_hold");
        expect_at(e + 100, 0, M_ALL, 105, 0, 0, 0, "paused_hold2");
        press(3'b001, e - 4);

        r = e + 104;
        expect_at(r, 0, M_ALL, 105, 1, 0, 0, "resume");
        expect_at(r + 5, 0, M_ALL, 105, 1, 0, 0, "resume_pre_tick");
        expect_at(r + 6, 0, M_ALL, 106, 1, 0, 0, "resume_tick_at_5");
        press(3'b001, e + 100);
        R2 = r - 5;

        // Lap freeze at 00:01:23, release at live 00:01:73.
        l = R2 + 183;
        expect_at(l - 1, 0, M_ALL, 123, 1, 0, 0, "pre_lap");
        expect_at(l, 0, M_ALL, 123, 1, 1, 0, "lap_set");
        expect_at(l + 250, 0, M_ALL, 123, 1, 1, 0, "lap_frozen");
        expect_at(l + 500, 0, M_ALL, 123, 1, 1, 0, "lap_frozen2");
        press(3'b010, R2 + 179);
        l2 = R2 + 687;
        expect_at(l2, 0, M_ALL, 123, 1, 0, 0, "lap_release");
        expect_at(l2 + 1, 0, M_ALL, 173, 1, 0, 0, "lap_live");
        press(3'b010, R2 + 683);

        // Clear in RUN is ignored; then lap, pause, clear in PAUSE.
        expect_at(R2 + 711, 0, M_ALL, 176, 1, 0, 0, "clear_in_run");
        expect_at(R2 + 718, 0, M_ALL, 176, 1, 1, 0, "lap_again");
        press(3'b100, R2 + 700);
        press(3'b010, R2 + 712);
        p = R2 + 724;
        expect_at(p, 0, M_ALL, 176, 0, 1, 0, "pause_keeps_lap");
        expect_at(p + 5, 0, M_ALL, 176, 0, 1, 0, "pause_snap");
        expect_at(p + 13, 0, M_ALL, 176, 0, 1, 0, "pre_clear");
        expect_at(p + 14, 0, M_ALL, 176, 0, 0, 0, "clear_lap_off");
        expect_at(p + 15, 0, M_ALL, 0, 0, 0, 0, "clear_zero");
        expect_at(p + 30, 0, M_ALL, 0, 0, 0, 0, "idle_after_clear");
        press(3'b001, R2 + 720);
        press(3'b100, p + 10);

        // Restart, pause at 3, then StartStop and Clear together resume.
        R3 = p + 44;
        expect_at(R3 - 1, 0, M_ALL, 0, 0, 0, 0, "restart_pre");
        expect_at(R3, 0, M_ALL, 0, 1, 0, 0, "restart");
        expect_at(R3 + 34, 0, M_ALL, 3, 0, 0, 0, "pause3");
        expect_at(R3 + 53, 0, M_ALL, 3, 0, 0, 0, "pre_combo");
        expect_at(R3 + 54, 0, M_ALL, 3, 1, 0, 0, "combo_run");
        expect_at(R3 + 60, 0, M_ALL, 3, 1, 0, 0, "combo_hold");
        expect_at(R3 + 61, 0, M_ALL, 4, 1, 0, 0, "combo_tick");
        press(3'b001, p + 40);
        press(3'b001, R3 + 30);
        press(3'b101, R3 + 50);

        // Wrap instance: DIV=2, MAX_MIN=1, rollover on tick 12000.
        W  = R3 + 100;
        RW = W + 4;
        expect_at(RW - 1, 1, M_ALL, 0, 0, 0, 0, "w_pre_run");
        expect_at(RW, 1, M_ALL, 0, 1, 0, 0, "w_run");
        expect_at(RW + 12000, 1, M_ALL, 5999, 1, 0, 0, "w_0_59_99");
        expect_at(RW + 12001, 1, M_ALL, 6000, 1, 0, 0, "w_min_carry");
        expect_at(RW + 24000, 1, M_ALL, 11999, 1, 0, 0, "w_1_59_99");
        expect_at(RW + 24001, 1, M_ALL, 0, 1, 0, 1, "w_wrap");
        expect_at(RW + 24002, 1, M_ALL, 0, 1, 0, 0, "w_wrap_end");
        expect_at(RW + 24003, 1, M_ALL, 1, 1, 0, 0, "w_continue");
        wait_until(W);
        wss = 1'b1;
        wait_until(W + 2);
        wss = 1'b0;

        wait_until(RW + 24010);
        total++;
        if (wrap_hi != 1) begin
            bad++;
            $display("FAIL wrap_width: got %0d high cycles, want 1", wrap_hi);
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending checks, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
